// File: rtl/knapsack_stream_checker.sv
// knapsack_stream_checker
//   Sequential knapsack scoring engine. A runtime-loadable table holds one
//   value/weight/volume coefficient triple per item. A selection vector is
//   accepted, then one item is accumulated per cycle into saturating totals.
//   The result is then reported with pass/fail against the thresholds that
//   were latched together with the selection.
//
//   Handshakes (both ports): a transfer happens on a rising clock edge where
//   valid and ready are both high. in_ready is high only in IDLE. Once
//   res_valid is raised, res_valid and all res_* outputs hold stable until that
//   transfer. in_ready returns the cycle after the result transfer.
//
//   Optional feature: define EARLY_ABORT_EN to end a run as soon as the running
//   weight or volume exceeds its limit (res_abort=1). Without it, res_abort is 0.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   cfg_we/cfg_addr/cfg_value/
//   cfg_weight/cfg_volume            table write port (IDLE only, addr < N_ITEMS)
//   min_value/max_weight/max_volume  pass thresholds, latched on accept
//   in_valid/in_ready/sel            selection input handshake
//   res_valid/res_ready              result handshake
//   res_ok/res_abort                 pass flag / early-abort flag
//   res_value/res_weight/res_volume  totals
module knapsack_stream_checker #(
  parameter int N_ITEMS = 17,
  parameter int COEF_W  = 5,
  parameter int ACC_W   = 9,
  parameter int IDX_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [COEF_W-1:0]  cfg_value,
  input  logic [COEF_W-1:0]  cfg_weight,
  input  logic [COEF_W-1:0]  cfg_volume,
  input  logic [ACC_W-1:0]   min_value,
  input  logic [ACC_W-1:0]   max_weight,
  input  logic [ACC_W-1:0]   max_volume,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_ITEMS-1:0] sel,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_ok,
  output logic               res_abort,
  output logic [ACC_W-1:0]   res_value,
  output logic [ACC_W-1:0]   res_weight,
  output logic [ACC_W-1:0]   res_volume
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);

  state_t             state;
  logic [COEF_W-1:0]  tbl_value  [N_ITEMS];
  logic [COEF_W-1:0]  tbl_weight [N_ITEMS];
  logic [COEF_W-1:0]  tbl_volume [N_ITEMS];
  logic [N_ITEMS-1:0] sel_q;
  logic [ACC_W-1:0]   min_q, maxw_q, maxv_q;
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   acc_value, acc_weight, acc_volume;
  logic               abort_q;

  logic [COEF_W-1:0]  add_value, add_weight, add_volume;
  logic [ACC_W-1:0]   next_value, next_weight, next_volume;

  // Zero-extended add with one carry bit; on carry, clamp to all-ones.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [COEF_W-1:0] coef);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W+1-COEF_W){1'b0}}, coef};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

  always_comb begin
    add_value   = '0;
    add_weight  = '0;
    add_volume  = '0;
    if (sel_q[idx]) begin
      add_value  = tbl_value[idx];
      add_weight = tbl_weight[idx];
      add_volume = tbl_volume[idx];
    end
    next_value  = sat_add(acc_value, add_value);
    next_weight = sat_add(acc_weight, add_weight);
    next_volume = sat_add(acc_volume, add_volume);
  end

  // Coefficient table: writable only while idle, so a run sees a fixed table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        tbl_value[i]  <= '0;
        tbl_weight[i] <= '0;
        tbl_volume[i] <= '0;
      end
    end else if (cfg_we && state == ST_IDLE && cfg_addr <= LAST_IDX) begin
      tbl_value[cfg_addr]  <= cfg_value;
      tbl_weight[cfg_addr] <= cfg_weight;
      tbl_volume[cfg_addr] <= cfg_volume;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      res_valid  <= 1'b0;
      res_ok     <= 1'b0;
      sel_q      <= '0;
      min_q      <= '0;
      maxw_q     <= '0;
      maxv_q     <= '0;
      idx        <= '0;
      acc_value  <= '0;
      acc_weight <= '0;
      acc_volume <= '0;
      abort_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            sel_q      <= sel;
            min_q      <= min_value;
            maxw_q     <= max_weight;
            maxv_q     <= max_volume;
            idx        <= '0;
            acc_value  <= '0;
            acc_weight <= '0;
            acc_volume <= '0;
            abort_q    <= 1'b0;
            in_ready   <= 1'b0;
            state      <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_value  <= next_value;
          acc_weight <= next_weight;
          acc_volume <= next_volume;
          idx        <= idx + 1'b1;
`ifdef EARLY_ABORT_EN
          // Sums never decrease, so the first overshoot already decides failure.
          if (next_weight > maxw_q || next_volume > maxv_q) begin
            abort_q <= 1'b1;
            state   <= ST_DONE;
          end else
`endif
          if (idx == LAST_IDX) state <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle evaluates the final totals; res_valid follows.
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_ok    <= !abort_q && (acc_value >= min_q) &&
                         (acc_weight <= maxw_q) && (acc_volume <= maxv_q);
          end else if (res_ready) begin
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EARLY_ABORT_EN
  assign res_abort = res_valid & abort_q;
`else
  assign res_abort = 1'b0;
`endif

  assign res_value  = acc_value;
  assign res_weight = acc_weight;
  assign res_volume = acc_volume;

endmodule

// File: tb/tb_knapsack_stream_checker.sv
module tb_knapsack_stream_checker;

  localparam int N = 17;
  localparam int SAT = 511;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [4:0]  cfg_value = '0, cfg_weight = '0, cfg_volume = '0;
  logic [8:0]  min_value = '0, max_weight = '0, max_volume = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] sel = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_ok, res_abort;
  logic [8:0]  res_value, res_weight, res_volume;

  knapsack_stream_checker dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_value(cfg_value),
    .cfg_weight(cfg_weight), .cfg_volume(cfg_volume),
    .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_ok(res_ok), .res_abort(res_abort),
    .res_value(res_value), .res_weight(res_weight), .res_volume(res_volume)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference table
  int tv [N];
  int tw [N];
  int to [N];

  // expected result: {abort, ok, value, weight, volume}
  logic [28:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      tv[i] = 0; tw[i] = 0; to[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; res_ready = 1'b0; cfg_we = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_clear();
    tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_item(input int a, input int v, input int w, input int o);
    cfg_we = 1'b1; cfg_addr = 5'(a);
    cfg_value = 5'(v); cfg_weight = 5'(w); cfg_volume = 5'(o);
    tick();
    cfg_we = 1'b0;
    if (a < N) begin
      tv[a] = v; tw[a] = w; to[a] = o;
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) load_item(i, 0, 0, 0);
  endtask

  function automatic int clip(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  // Runs one selection end to end and checks latency, totals and flags.
  task automatic run_check(input string tag, input logic [16:0] s, input int mn,
                           input int mw, input int mv, input int hold, input bit pulse_cfg);
    int sv, sw, so, lat, exp_lat, cyc;
    bit ab, ok;
    logic [28:0] e;
    logic [8:0] snap_v;
    sv = 0; sw = 0; so = 0; ab = 0; exp_lat = N + 1;
    for (int i = 0; i < N; i++) begin
      if (s[i]) begin
        sv += tv[i]; sw += tw[i]; so += to[i];
      end
`ifdef EARLY_ABORT_EN
      if (clip(sw) > mw || clip(so) > mv) begin
        ab = 1; exp_lat = i + 2;
        break;
      end
`endif
    end
    ok = !ab && clip(sv) >= mn && clip(sw) <= mw && clip(so) <= mv;
    exp_q.push_back({ab, ok, 9'(clip(sv)), 9'(clip(sw)), 9'(clip(so))});

    cyc = 0;
    while (!in_ready && cyc < 50) begin tick(); cyc++; end
    check({tag, ":in_ready"}, 32'(in_ready), 1);
    sel = s; min_value = 9'(mn); max_weight = 9'(mw); max_volume = 9'(mv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // later threshold changes must not matter
    min_value = 9'($urandom_range(0, SAT));
    max_weight = 9'($urandom_range(0, SAT));
    max_volume = 9'($urandom_range(0, SAT));
    sel = 17'($urandom);

    lat = 0;
    while (lat < 60) begin
      tick(); lat++;
      if (res_valid) break;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));

    e = exp_q.pop_front();
    check({tag, ":abort"},  32'(res_abort),  32'(e[28]));
    check({tag, ":ok"},     32'(res_ok),     32'(e[27]));
    check({tag, ":value"},  32'(res_value),  32'(e[26:18]));
    check({tag, ":weight"}, 32'(res_weight), 32'(e[17:9]));
    check({tag, ":volume"}, 32'(res_volume), 32'(e[8:0]));

    snap_v = res_value;
    for (int h = 0; h < hold; h++) begin
      if (pulse_cfg) begin
        cfg_we = 1'b1; cfg_addr = 5'(h % 2);
        cfg_value = 5'd31; cfg_weight = 5'd31; cfg_volume = 5'd31;
      end
      tick();
      cfg_we = 1'b0;
      check({tag, ":hold_valid"}, 32'(res_valid), 1);
      check({tag, ":hold_inrdy"}, 32'(in_ready), 0);
      check({tag, ":hold_value"}, 32'(res_value), 32'(snap_v));
      check({tag, ":hold_ok"},    32'(res_ok), 32'(e[27]));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, ":post_valid"}, 32'(res_valid), 0);
    check({tag, ":post_inrdy"}, 32'(in_ready), 1);
  endtask

  task automatic load_t1();
    clear_table();
    load_item(0, 20, 10, 10);
    load_item(1, 30, 25, 5);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    do_reset();
    check("rst:in_ready",  32'(in_ready), 1);
    check("rst:res_valid", 32'(res_valid), 0);
    check("rst:res_ok",    32'(res_ok), 0);
    check("rst:res_abort", 32'(res_abort), 0);
    check("rst:value",     32'(res_value), 0);
    check("rst:weight",    32'(res_weight), 0);
    check("rst:volume",    32'(res_volume), 0);

    // T1/T2
    load_t1();
    load_item(20, 31, 31, 31);   // out of range, ignored
    run_check("t1", 17'h00003, 40, 60, 60, 0, 0);
    run_check("t2a", 17'h00003, 51, 60, 60, 0, 0);
    run_check("t2b", 17'h00003, 50, 35, 15, 1, 0);
    run_check("sel0a", 17'h00000, 0, 0, 0, 0, 0);
    run_check("sel0b", 17'h00000, 1, 0, 0, 0, 0);

    // T3: saturation
    for (int i = 0; i < N; i++) load_item(i, 31, 0, 0);
    run_check("t3", 17'h1FFFF, 511, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) load_item(i, 0, 31, 31);
    run_check("t3w", 17'h1FFFF, 0, 510, 511, 0, 0);

    // T4: weight overshoot
    clear_table();
    load_item(0, 0, 31, 0);
    load_item(1, 0, 31, 0);
    run_check("t4", 17'h00003, 0, 60, 511, 0, 0);

    // T5: hold in DONE with ignored table writes, then re-run T1
    load_t1();
    run_check("t5", 17'h00003, 40, 60, 60, 10, 1);
    run_check("t5re", 17'h00003, 40, 60, 60, 0, 0);

    // T6: reset mid-run
    sel = 17'h00003; min_value = 9'd40; max_weight = 9'd60; max_volume = 9'd60;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("t6:in_ready",  32'(in_ready), 1);
    check("t6:res_valid", 32'(res_valid), 0);
    check("t6:value",     32'(res_value), 0);
    check("t6:weight",    32'(res_weight), 0);
    #12;
    rst_n = 1'b1;
    model_clear();
    tick();
    load_t1();
    run_check("t6re", 17'h00003, 40, 60, 60, 0, 0);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 4; k++)
        load_item($urandom_range(0, N - 1), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31));
      run_check("rnd", 17'($urandom), $urandom_range(0, 300),
                $urandom_range(0, 511), $urandom_range(0, 511),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
